// File: rtl/data_memory_if.sv
// Request/response bus between the processor's data port and data_memory.
// The processor drives the request side; the memory answers with ack/busy/rdata.
interface data_memory_if;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        rstrb;
  logic [31:0] rdata;
  logic        ack;
  logic        busy;

  modport master (
    output address, wdata, wmask, rstrb,
    input  rdata, ack, busy
  );

  modport slave (
    input  address, wdata, wmask, rstrb,
    output rdata, ack, busy
  );
endinterface

// File: rtl/data_memory.sv
// Data-side memory responder: word RAM with byte-lane writes, programmable
// wait states before the ack pulse, and one memory-mapped LED register on
// the IO page. Writes commit at acceptance; reads return the pre-write value.
module data_memory #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1,
  parameter int IO_BIT      = 22
) (
  input  logic          CLK,
  input  logic          RESET,
  data_memory_if.slave  bus,
  output logic [31:0]   LEDS
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_RESPOND = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rd_q;
  logic [31:0] capt_q;
  logic [31:0] rdata_q;
  logic [31:0] leds_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic          io_sel;
  logic          led_sel;
  logic          req;
  logic          accept;
  logic [31:0]   rd_val;
  logic          load_rdata;
  logic [31:0]   rdata_src;
  logic          unused_addr;

  // Replace only the enabled byte lanes of a word.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  // Upper address bits beyond the RAM index are deliberately ignored (wrap).
  assign unused_addr = ^bus.address;

  assign idx     = bus.address[AW+1:2];
  assign io_sel  = bus.address[IO_BIT];
  assign led_sel = io_sel && (bus.address[5:2] == 4'd1);
  assign req     = bus.rstrb || (bus.wmask != 4'd0);
  assign accept  = (state_q == S_IDLE) && req;

  // Pre-write read value: RAM word, LED register, or zero for unmapped IO.
  always_comb begin
    rd_val = 32'd0;
    if (!io_sel)      rd_val = mem[idx];
    else if (led_sel) rd_val = leds_q;
  end

  // Next-state logic; also decides when the read result is published on rdata.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load_rdata = 1'b0;
    rdata_src  = capt_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WS_INIT;
          end else begin
            state_d    = S_RESPOND;
            load_rdata = bus.rstrb;
            rdata_src  = rd_val;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = S_RESPOND;
          load_rdata = rd_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESPOND: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Control state, response register and LED register with async reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rd_q    <= 1'b0;
      rdata_q <= 32'd0;
      leds_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) rd_q <= bus.rstrb;
      if (load_rdata) rdata_q <= rdata_src;
      if (accept && led_sel) leds_q <= merge_lanes(leds_q, bus.wdata, bus.wmask);
    end
  end

  // Read value captured at acceptance and held until the respond cycle.
  always_ff @(posedge CLK) begin
    if (accept && bus.rstrb) capt_q <= rd_val;
  end

  // RAM write port: masked lanes commit on the acceptance edge; not reset.
  always_ff @(posedge CLK) begin
    if (accept && !RESET && !io_sel && (bus.wmask != 4'd0)) begin
      mem[idx] <= merge_lanes(mem[idx], bus.wdata, bus.wmask);
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ack   = (state_q == S_RESPOND);
  assign bus.busy  = (state_q != S_IDLE);
  assign LEDS      = leds_q;

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: one instance with one wait state and full
// depth, one with zero wait states and a 16-word RAM for the wrap case.
module tb_data_memory;

  logic        clk;
  logic        rst;
  logic [31:0] leds0;
  logic [31:0] leds1;
  int          checks;
  int          fails;

  data_memory_if m0 ();
  data_memory_if m1 ();

  data_memory #(.DEPTH_WORDS(1024), .WAIT_STATES(1), .IO_BIT(22)) dut0 (
    .CLK(clk), .RESET(rst), .bus(m0), .LEDS(leds0)
  );

  data_memory #(.DEPTH_WORDS(16), .WAIT_STATES(0), .IO_BIT(22)) dut1 (
    .CLK(clk), .RESET(rst), .bus(m1), .LEDS(leds1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request on instance 0 and observe the following six cycles.
  task automatic req0(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm,
                      input logic rs, output int lat, output int nack, output int bcnt,
                      output logic [31:0] rd, output logic [31:0] lds);
    @(negedge clk);
    m0.address = a; m0.wdata = wd; m0.wmask = wm; m0.rstrb = rs;
    @(posedge clk);
    #1;
    lds = leds0;
    m0.wmask = 4'd0; m0.rstrb = 1'b0;
    lat = -1; nack = 0; bcnt = 0; rd = 32'hxxxxxxxx;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (m0.busy) bcnt++;
      if (m0.ack) begin
        nack++;
        if (lat < 0) begin lat = k; rd = m0.rdata; end
      end
    end
  endtask

  // Same as req0 for instance 1.
  task automatic req1(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm,
                      input logic rs, output int lat, output int nack, output int bcnt,
                      output logic [31:0] rd);
    @(negedge clk);
    m1.address = a; m1.wdata = wd; m1.wmask = wm; m1.rstrb = rs;
    @(posedge clk);
    #1;
    m1.wmask = 4'd0; m1.rstrb = 1'b0;
    lat = -1; nack = 0; bcnt = 0; rd = 32'hxxxxxxxx;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (m1.busy) bcnt++;
      if (m1.ack) begin
        nack++;
        if (lat < 0) begin lat = k; rd = m1.rdata; end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (m0.ack !== 1'b0) begin fails++; $display("FAIL reset_ack: got %b expected 0", m0.ack); end
    checks++; if (m0.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", m0.busy); end
    checks++; if (m0.rdata !== 32'd0) begin fails++; $display("FAIL reset_rdata: got %h expected 0", m0.rdata); end
    checks++; if (leds0 !== 32'd0) begin fails++; $display("FAIL reset_leds: got %h expected 0", leds0); end
    checks++; if (m1.busy !== 1'b0) begin fails++; $display("FAIL reset_busy1: got %b expected 0", m1.busy); end
    rst = 1'b0;
  endtask

  task automatic test_word();
    int lat, nack, bcnt; logic [31:0] rd, lds;
    req0(32'h10, 32'hDEADBEEF, 4'hF, 1'b0, lat, nack, bcnt, rd, lds);
    checks++; if (lat !== 2) begin fails++; $display("FAIL word_wr_lat: got %0d expected 2", lat); end
    checks++; if (bcnt !== 2) begin fails++; $display("FAIL word_wr_busy: got %0d expected 2", bcnt); end
    checks++; if (nack !== 1) begin fails++; $display("FAIL word_wr_nack: got %0d expected 1", nack); end
    req0(32'h10, 32'h0, 4'h0, 1'b1, lat, nack, bcnt, rd, lds);
    checks++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL word_rd: got %h expected DEADBEEF", rd); end
    checks++; if (lat !== 2) begin fails++; $display("FAIL word_rd_lat: got %0d expected 2", lat); end
    checks++; if (bcnt !== 2) begin fails++; $display("FAIL word_rd_busy: got %0d expected 2", bcnt); end
    // A write ack leaves rdata at the last read value.
    req0(32'h14, 32'h01020304, 4'hF, 1'b0, lat, nack, bcnt, rd, lds);
    checks++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL word_wr_rdata_hold: got %h expected DEADBEEF", rd); end
  endtask

  task automatic test_byte_lane();
    int lat, nack, bcnt; logic [31:0] rd, lds;
    req0(32'h20, 32'h11223344, 4'hF, 1'b0, lat, nack, bcnt, rd, lds);
    req0(32'h20, 32'h0000AA00, 4'b0010, 1'b0, lat, nack, bcnt, rd, lds);
    req0(32'h20, 32'h0, 4'h0, 1'b1, lat, nack, bcnt, rd, lds);
    checks++; if (rd !== 32'h1122AA44) begin fails++; $display("FAIL lane_b1: got %h expected 1122AA44", rd); end
    req0(32'h20, 32'h55660000, 4'b1100, 1'b0, lat, nack, bcnt, rd, lds);
    req0(32'h20, 32'h0, 4'h0, 1'b1, lat, nack, bcnt, rd, lds);
    checks++; if (rd !== 32'h5566AA44) begin fails++; $display("FAIL lane_b23: got %h expected 5566AA44", rd); end
  endtask

  task automatic test_led();
    int lat, nack, bcnt; logic [31:0] rd, lds;
    req0(32'h4, 32'hCAFEF00D, 4'hF, 1'b0, lat, nack, bcnt, rd, lds);
    req0((32'd1 << 22) | 32'h4, 32'h000000A5, 4'hF, 1'b0, lat, nack, bcnt, rd, lds);
    checks++; if (lds !== 32'h000000A5) begin fails++; $display("FAIL led_at_accept: got %h expected 000000A5", lds); end
    req0((32'd1 << 22) | 32'h4, 32'h0, 4'h0, 1'b1, lat, nack, bcnt, rd, lds);
    checks++; if (rd !== 32'h000000A5) begin fails++; $display("FAIL led_rd: got %h expected 000000A5", rd); end
    req0((32'd1 << 22) | 32'h8, 32'h0, 4'h0, 1'b1, lat, nack, bcnt, rd, lds);
    checks++; if (rd !== 32'h0) begin fails++; $display("FAIL io_other_rd: got %h expected 0", rd); end
    req0((32'd1 << 22) | 32'h8, 32'hFFFFFFFF, 4'hF, 1'b0, lat, nack, bcnt, rd, lds);
    checks++; if (leds0 !== 32'h000000A5) begin fails++; $display("FAIL io_other_wr: got %h expected 000000A5", leds0); end
    req0(32'h4, 32'h0, 4'h0, 1'b1, lat, nack, bcnt, rd, lds);
    checks++; if (rd !== 32'hCAFEF00D) begin fails++; $display("FAIL led_ram_word1: got %h expected CAFEF00D", rd); end
  endtask

  task automatic test_busy_ignore();
    int lat, nack, bcnt; logic [31:0] rd, lds;
    int acks;
    req0(32'h30, 32'h12345678, 4'hF, 1'b0, lat, nack, bcnt, rd, lds);
    @(negedge clk);
    m0.address = 32'h10; m0.rstrb = 1'b1;
    @(posedge clk);
    #1;
    m0.rstrb = 1'b0; m0.address = 32'h30; m0.wdata = 32'hFFFFFFFF; m0.wmask = 4'hF;
    acks = 0;
    repeat (2) begin @(negedge clk); if (m0.ack) acks++; end
    @(posedge clk);
    #1;
    m0.wmask = 4'h0;
    repeat (4) begin @(negedge clk); if (m0.ack) acks++; end
    checks++; if (acks !== 1) begin fails++; $display("FAIL busy_extra_ack: got %0d expected 1", acks); end
    req0(32'h30, 32'h0, 4'h0, 1'b1, lat, nack, bcnt, rd, lds);
    checks++; if (rd !== 32'h12345678) begin fails++; $display("FAIL busy_ignored_wr: got %h expected 12345678", rd); end
    // Simultaneous read and write returns the old word.
    req0(32'h40, 32'h7, 4'hF, 1'b0, lat, nack, bcnt, rd, lds);
    req0(32'h40, 32'h9, 4'hF, 1'b1, lat, nack, bcnt, rd, lds);
    checks++; if (rd !== 32'h7) begin fails++; $display("FAIL rbw_old: got %h expected 7", rd); end
    checks++; if (nack !== 1) begin fails++; $display("FAIL rbw_nack: got %0d expected 1", nack); end
    req0(32'h40, 32'h0, 4'h0, 1'b1, lat, nack, bcnt, rd, lds);
    checks++; if (rd !== 32'h9) begin fails++; $display("FAIL rbw_new: got %h expected 9", rd); end
  endtask

  task automatic test_wrap_ws0();
    int lat, nack, bcnt; logic [31:0] rd;
    req1(32'h44, 32'h1234, 4'hF, 1'b0, lat, nack, bcnt, rd);
    checks++; if (lat !== 1) begin fails++; $display("FAIL ws0_wr_lat: got %0d expected 1", lat); end
    req1(32'h04, 32'h0, 4'h0, 1'b1, lat, nack, bcnt, rd);
    checks++; if (rd !== 32'h1234) begin fails++; $display("FAIL wrap_rd: got %h expected 1234", rd); end
    checks++; if (lat !== 1) begin fails++; $display("FAIL ws0_rd_lat: got %0d expected 1", lat); end
    checks++; if (bcnt !== 1) begin fails++; $display("FAIL ws0_busy: got %0d expected 1", bcnt); end
  endtask

  task automatic test_async_reset();
    int lat, nack, bcnt; logic [31:0] rd, lds;
    int acks;
    req0(32'h50, 32'hA5A5A5A5, 4'hF, 1'b0, lat, nack, bcnt, rd, lds);
    req0((32'd1 << 22) | 32'h4, 32'hFF, 4'hF, 1'b0, lat, nack, bcnt, rd, lds);
    req0(32'h10, 32'h0, 4'h0, 1'b1, lat, nack, bcnt, rd, lds);
    @(negedge clk);
    m0.address = 32'h50; m0.rstrb = 1'b1;
    @(posedge clk);
    #1;
    m0.rstrb = 1'b0;
    checks++; if (m0.busy !== 1'b1) begin fails++; $display("FAIL ar_busy_before: got %b expected 1", m0.busy); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (m0.busy !== 1'b0) begin fails++; $display("FAIL ar_busy: got %b expected 0", m0.busy); end
    checks++; if (m0.ack !== 1'b0) begin fails++; $display("FAIL ar_ack: got %b expected 0", m0.ack); end
    checks++; if (leds0 !== 32'h0) begin fails++; $display("FAIL ar_leds: got %h expected 0", leds0); end
    checks++; if (m0.rdata !== 32'h0) begin fails++; $display("FAIL ar_rdata: got %h expected 0", m0.rdata); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    acks = 0;
    repeat (5) begin @(negedge clk); if (m0.ack) acks++; end
    checks++; if (acks !== 0) begin fails++; $display("FAIL ar_no_ack: got %0d expected 0", acks); end
    req0(32'h50, 32'h0, 4'h0, 1'b1, lat, nack, bcnt, rd, lds);
    checks++; if (rd !== 32'hA5A5A5A5) begin fails++; $display("FAIL ar_ram_kept: got %h expected A5A5A5A5", rd); end
    req0(32'h10, 32'h0, 4'h0, 1'b1, lat, nack, bcnt, rd, lds);
    checks++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL ar_ram_kept2: got %h expected DEADBEEF", rd); end
  endtask

  initial begin
    checks = 0; fails = 0;
    rst = 1'b1;
    m0.address = 32'd0; m0.wdata = 32'd0; m0.wmask = 4'd0; m0.rstrb = 1'b0;
    m1.address = 32'd0; m1.wdata = 32'd0; m1.wmask = 4'd0; m1.rstrb = 1'b0;
    test_reset();
    test_word();
    test_byte_lane();
    test_led();
    test_busy_ignore();
    test_wrap_ws0();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
